// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage in front of a 64x16 code memory with combinational read.
//   The program counter drives the memory address directly; the returned word
//   is captured into a single-entry output slot and presented to decode over
//   a valid/ready handshake. Supports start-from-address, branch redirect with
//   flush, and stops fetching after loading a halt-opcode word.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            pulse, begin fetching at start_addr (IDLE/HALTED only)
//   start_addr       first fetch address
//   mem_addr         code memory read address (wire from pc)
//   mem_rdata        code memory read data
//   instr            registered instruction
//   instr_pc         address instr was fetched from
//   instr_valid      slot holds an unconsumed word
//   instr_ready      decode accepts instr this cycle
//   redirect_valid   branch taken: flush slot, refetch at redirect_addr
//   redirect_addr    branch target
//   pc               next fetch address
//   halted           FSM in HALTED
//   pc_wrap          one-cycle pulse after pc increments from all-ones to 0
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int unsigned           ADDR_W   = 6,
  parameter int unsigned           DATA_W   = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter logic [3:0]            HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              pc_wrap
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // Output slot: one instruction plus the address it came from.
  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic              vld;
  } slot_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  slot_t             slot_q, slot_d;
  logic              wrap_q, wrap_d;

  logic              load;
  logic              consume;
  logic              is_halt;
  logic              pc_max;

  // Slot may be refilled when it is empty or being drained this cycle.
  assign load    = !slot_q.vld || instr_ready;
  assign consume = slot_q.vld && instr_ready;
  assign is_halt = (mem_rdata[DATA_W-1 -: 4] == HALT_OP);
  assign pc_max  = (pc_q == {ADDR_W{1'b1}});

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    slot_d  = slot_q;
    wrap_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (redirect_valid) begin
          // Flush: the word at the old pc is wrong-path, drop any pending slot.
          pc_d       = redirect_addr;
          slot_d.vld = 1'b0;
        end else if (load) begin
          slot_d.instr = mem_rdata;
          slot_d.pc    = pc_q;
          slot_d.vld   = 1'b1;
          if (is_halt) begin
            // pc stays on the halt word so a later inspection sees where we stopped.
            state_d = ST_HALTED;
          end else begin
            pc_d   = pc_q + ADDR_W'(1);
            wrap_d = pc_max;
          end
        end
      end

      ST_HALTED: begin
        // The halt word is still owed to decode; only drain, never load.
        if (consume) slot_d.vld = 1'b0;
        if (start) begin
          pc_d    = start_addr;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      slot_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
      wrap_q  <= wrap_d;
    end
  end

  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign instr       = slot_q.instr;
  assign instr_pc    = slot_q.pc;
  assign instr_valid = slot_q.vld;
  assign halted      = (state_q == ST_HALTED);
  assign pc_wrap     = wrap_q;

endmodule
